// File: rtl/cascade_and_arbiter.sv
// Two-requester round-robin front end feeding a shared LATENCY-stage cascaded-AND pipeline.
// Results come back tagged with the requester ID; en low freezes the whole pipeline.
module cascade_and_arbiter #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt1,
   output logic             res_valid,
   output logic             res_id,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   typedef enum logic {
      PRI_0 = 1'b0,
      PRI_1 = 1'b1
   } pri_t;

   pri_t ptr_q, ptr_d;

   logic [LATENCY-1:0]            vld_q,  vld_d;
   logic [LATENCY-1:0]            id_q,   id_d;
   logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;

   logic active;
   logic gnt0_c;
   logic gnt1_c;

   // Contention resolves to the pointer; a lone requester always wins.
   always_comb begin
      active = en & ~rst;
      gnt0_c = active & req0 & (~req1 | (ptr_q == PRI_0));
      gnt1_c = active & req1 & (~req0 | (ptr_q == PRI_1));

      ptr_d = ptr_q;
      if (gnt0_c) begin
         ptr_d = PRI_1;
      end else if (gnt1_c) begin
         ptr_d = PRI_0;
      end
   end

   always_comb begin
      vld_d  = vld_q;
      id_d   = id_q;
      data_d = data_q;
      if (en) begin
         vld_d[0] = gnt0_c | gnt1_c;
         id_d[0]  = gnt1_c;
         if (gnt1_c) begin
            data_d[0] = a1 & b1;
         end else if (gnt0_c) begin
            data_d[0] = a0 & b0;
         end else begin
            data_d[0] = '0;
         end
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            id_d[i]   = id_q[i-1];
            data_d[i] = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= PRI_0;
         vld_q  <= '0;
         id_q   <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         vld_q  <= vld_d;
         id_q   <= id_d;
         data_q <= data_d;
      end
   end

   assign gnt0      = gnt0_c;
   assign gnt1      = gnt1_c;
   assign res_valid = vld_q[LATENCY-1];
   assign res_id    = id_q[LATENCY-1];
   assign res_data  = data_q[LATENCY-1];
   assign busy      = |vld_q;

endmodule

// File: tb/tb_cascade_and_arbiter.sv
// Scoreboard bench: default instance (WIDTH=1, LATENCY=2) plus a WIDTH=4, LATENCY=3 instance.
module tb_cascade_and_arbiter;

   localparam int LAT_A = 2;
   localparam int LAT_B = 3;

   logic clk = 1'b0;
   logic rst;
   logic en;

   logic       req0_a, req1_a, gnt0_a, gnt1_a;
   logic [0:0] a0_a, b0_a, a1_a, b1_a, res_data_a;
   logic       res_valid_a, res_id_a, busy_a;

   logic       req0_b, req1_b, gnt0_b, gnt1_b;
   logic [3:0] a0_b, b0_b, a1_b, b1_b, res_data_b;
   logic       res_valid_b, res_id_b, busy_b;

   typedef struct {
      logic       id;
      logic [3:0] data;
      int         due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int   checks   = 0;
   int   failures = 0;
   int   ecnt     = 0;
   logic ptr_a    = 1'b0;
   logic ptr_b    = 1'b0;

   always #5 clk = ~clk;

   cascade_and_arbiter #(.WIDTH(1), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst(rst), .en(en),
      .req0(req0_a), .a0(a0_a), .b0(b0_a), .gnt0(gnt0_a),
      .req1(req1_a), .a1(a1_a), .b1(b1_a), .gnt1(gnt1_a),
      .res_valid(res_valid_a), .res_id(res_id_a), .res_data(res_data_a), .busy(busy_a)
   );

   cascade_and_arbiter #(.WIDTH(4), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .rst(rst), .en(en),
      .req0(req0_b), .a0(a0_b), .b0(b0_b), .gnt0(gnt0_b),
      .req1(req1_b), .a1(a1_b), .b1(b1_b), .gnt1(gnt1_b),
      .res_valid(res_valid_b), .res_id(res_id_b), .res_data(res_data_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [1:0] arb(input logic r0, input logic r1, input logic ptr,
                                      input logic act);
      logic [1:0] g;
      g = 2'b00;
      if (act) begin
         if (r0 && (!r1 || !ptr))     g = 2'b01;
         else if (r1 && (!r0 || ptr)) g = 2'b10;
      end
      return g;
   endfunction

   // Enabled, non-reset edges; a pair accepted before count k surfaces when count = k+LATENCY.
   always @(posedge clk) begin
      if (!rst && en) ecnt <= ecnt + 1;
   end

   task automatic step();
      logic [1:0] ea, eb;
      @(negedge clk);
      ea = arb(req0_a, req1_a, ptr_a, en && !rst);
      eb = arb(req0_b, req1_b, ptr_b, en && !rst);
      chk("gnt0_a", gnt0_a, ea[0]);
      chk("gnt1_a", gnt1_a, ea[1]);
      chk("gnt0_b", gnt0_b, eb[0]);
      chk("gnt1_b", gnt1_b, eb[1]);
      if (ea[0]) qa.push_back('{id: 1'b0, data: 4'(a0_a & b0_a), due: ecnt + LAT_A});
      if (ea[1]) qa.push_back('{id: 1'b1, data: 4'(a1_a & b1_a), due: ecnt + LAT_A});
      if (eb[0]) qb.push_back('{id: 1'b0, data: a0_b & b0_b, due: ecnt + LAT_B});
      if (eb[1]) qb.push_back('{id: 1'b1, data: a1_b & b1_b, due: ecnt + LAT_B});
      if (rst)        ptr_a = 1'b0;
      else if (ea[0]) ptr_a = 1'b1;
      else if (ea[1]) ptr_a = 1'b0;
      if (rst)        ptr_b = 1'b0;
      else if (eb[0]) ptr_b = 1'b1;
      else if (eb[1]) ptr_b = 1'b0;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && en) begin
         while (qa.size() > 0 && qa[0].due < ecnt) begin
            fail_now("late_result_a");
            void'(qa.pop_front());
         end
         if (res_valid_a) begin
            if (qa.size() == 0) begin
               fail_now("unexpected_result_a");
            end else begin
               e = qa.pop_front();
               chk("res_id_a", res_id_a, e.id);
               chk("res_data_a", res_data_a, e.data[0:0]);
               chk("res_time_a", ecnt, e.due);
            end
         end
         while (qb.size() > 0 && qb[0].due < ecnt) begin
            fail_now("late_result_b");
            void'(qb.pop_front());
         end
         if (res_valid_b) begin
            if (qb.size() == 0) begin
               fail_now("unexpected_result_b");
            end else begin
               e = qb.pop_front();
               chk("res_id_b", res_id_b, e.id);
               chk("res_data_b", res_data_b, e.data);
               chk("res_time_b", ecnt, e.due);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1;
      req0_a = 1'b1; req1_a = 1'b1;
      a0_a = 1'b1; b0_a = 1'b1; a1_a = 1'b1; b1_a = 1'b0;
      req0_b = 1'b0; req1_b = 1'b0;
      a0_b = 4'h0; b0_b = 4'h0; a1_b = 4'h0; b1_b = 4'h0;

      // Reset held with both requests up: nothing granted, nothing valid.
      @(posedge clk);
      #1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_gnt0", gnt0_a, 1'b0);
         chk("rst_gnt1", gnt1_a, 1'b0);
         chk("rst_res_valid", res_valid_a, 1'b0);
         chk("rst_res_id", res_id_a, 1'b0);
         chk("rst_res_data", res_data_a, 1'b0);
         chk("rst_busy", busy_a, 1'b0);
         chk("rst_busy_b", busy_b, 1'b0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      // Contention: grants alternate starting at requester 0; data 1 from req0, 0 from req1.
      repeat (6) step();
      req0_a = 1'b0; req1_a = 1'b0;
      chk("busy_inflight", busy_a, 1'b1);
      repeat (4) step();
      chk("busy_drained", busy_a, 1'b0);

      // Single requester: 1&1 then 1&0.
      req0_a = 1'b1; a0_a = 1'b1; b0_a = 1'b1;
      step();
      a0_a = 1'b1; b0_a = 1'b0;
      step();
      req0_a = 1'b0;
      repeat (4) step();

      // Enable stall: pipeline holds; en-qualified result counted once.
      req0_a = 1'b1; a0_a = 1'b1; b0_a = 1'b1;
      step();
      req0_a = 1'b0;
      step();
      en = 1'b0; req0_a = 1'b1; req1_a = 1'b1;
      repeat (3) step();
      chk("busy_stalled", busy_a, 1'b1);
      chk("res_valid_held", res_valid_a, 1'b1);
      en = 1'b1; req0_a = 1'b0; req1_a = 1'b0;
      repeat (4) step();

      // Reset with two pairs in flight: discarded, pointer back to 0.
      req0_a = 1'b1; req1_a = 1'b1; b1_a = 1'b1;
      step();
      step();
      rst = 1'b1; req0_a = 1'b0; req1_a = 1'b0;
      qa.delete();
      step();
      chk("midrst_busy", busy_a, 1'b0);
      chk("midrst_res_valid", res_valid_a, 1'b0);
      rst = 1'b0; req0_a = 1'b1; req1_a = 1'b1;
      step();
      req0_a = 1'b0; req1_a = 1'b0;
      repeat (4) step();

      // WIDTH=4, LATENCY=3: 1101 & 0111 = 0101 from requester 1.
      req1_b = 1'b1; a1_b = 4'b1101; b1_b = 4'b0111;
      step();
      req1_b = 1'b0;
      repeat (5) step();
      chk("busy_b_drained", busy_b, 1'b0);

      chk("queue_a_empty", qa.size(), 0);
      chk("queue_b_empty", qb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
